two_port_req_mux: RTL and testbench
===================================

TWO_PORT_REQ_MUX -- requirements
Module: two_port_req_mux

Interface
REQ-001 Parameter ADDR_W, default 32, request address width.
REQ-002 Parameter DATA_W, default 64, write/read data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, response watchdog limit; used only when the watchdog is compiled in.
REQ-004 Port clock  in  1  single clock; all flops rising-edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Ports req_valid / req_ready  in / out  [1:0]  per-requester request handshake.
REQ-007 Ports req_we [1:0], req_addr [1:0][ADDR_W], req_wdata [1:0][DATA_W]  in  per-requester write flag, address, write data.
REQ-008 Ports resp_valid [1:0], resp_err [1:0]  out  one-cycle response pulse and error flag, per requester.
REQ-009 Port resp_rdata  out  [DATA_W]  read data shared by both requesters, qualified by resp_valid.
REQ-010 Ports arb_req / arb_grant / arb_ack  out [1:0] / in [1:0] / out 1  connect to the two-requester round-robin arbiter; arb_grant is registered, one-hot or zero.
REQ-011 Ports mem_req_valid, mem_req_ready, mem_req_we, mem_req_addr, mem_req_wdata  downstream request channel (valid out, ready in).
REQ-012 Ports mem_resp_valid, mem_resp_rdata  in  downstream response; no backpressure.

Function
REQ-013 Each port SHALL hold a one-entry request register; req_ready[i] = ~full[i]; capture on req_valid[i] & req_ready[i].
REQ-014 arb_req[i] SHALL equal full[i] and SHALL remain high until the ack cycle of that port's transaction.
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT_RESP, RELEASE.
REQ-016 IDLE: if (arb_grant & full) != 0, latch owner = that index and go to ISSUE; a grant to a non-full port SHALL be ignored.
REQ-017 ISSUE: mem_req_valid = 1 carrying the owner's entry; on mem_req_ready go to WAIT_RESP; payload stays stable while valid & ~ready.
REQ-018 WAIT_RESP: on mem_resp_valid, pulse resp_valid[owner] for one cycle with resp_rdata = mem_resp_rdata, then go to RELEASE.
REQ-019 RELEASE: arb_ack = 1 for exactly one cycle; full[owner] is cleared at the end of that cycle; next state is IDLE.
REQ-020 Response and ack SHALL NOT coincide; arb_ack is asserted only in RELEASE.
REQ-021 The non-owner port SHALL keep accepting and holding a request throughout; it is never dropped or reordered.
REQ-022 Minimum latency: accept at cycle 0 -> full at 1 -> grant visible at 2 -> ISSUE at 3 -> mem handshake at 3 when ready.
REQ-023 The owner port's req_ready SHALL NOT rise before the cycle after RELEASE; a new request on that port is a fresh arbitration.
REQ-024 A mem_resp_valid outside WAIT_RESP SHALL be ignored.

Reset
REQ-025 On reset low: state = IDLE; full = 0; owner = 0; req_ready = 2'b00; all valid/ack/resp/err outputs 0; data outputs 0.
REQ-026 Reset asserted mid-transaction SHALL abandon it with no response pulse; after deassertion req_ready = 2'b11 on the first clock.

Configuration
REQ-027 Macro TWO_PORT_REQ_MUX_TIMEOUT_EN: when defined, a counter runs in WAIT_RESP; on reaching TIMEOUT_CYCLES it pulses resp_valid[owner] with resp_err[owner] = 1 and resp_rdata = 0, then goes to RELEASE.
REQ-028 Without the macro, no counter is built, resp_err is tied to 0, and WAIT_RESP waits indefinitely.

Structure
REQ-029 Package two_port_req_mux_pkg SHALL hold the FSM state enum, the owner index typedef, and the request entry struct (we, addr, wdata).
REQ-030 Sub-module req_hold_slot SHALL implement one per-port holding register with its handshake, instantiated twice.

Verification
REQ-031 Single request on port 0 (we=0, addr 0x100), mem_req_ready=1, response 0xDEAD two cycles later -> resp_valid[0] pulse with rdata 0xDEAD; arb_ack one cycle later.
REQ-032 Both ports valid in the same cycle after reset -> port 0 served first, then port 1; exactly two arb_ack pulses; no lost request.
REQ-033 Port 0 re-requests immediately after each ack while port 1 stays pending -> service order alternates 0, 1, 0, 1.
REQ-034 mem_req_ready held low for 5 cycles -> mem_req_valid high and payload stable for all 5 cycles; single issue.
REQ-035 Macro defined, TIMEOUT_CYCLES = 8, no response -> resp_err[owner] = 1 on cycle 8 of WAIT_RESP, then arb_ack.
REQ-036 Reset asserted during WAIT_RESP -> all outputs 0 asynchronously; stale mem_resp_valid after release produces no resp_valid.

Source files
------------

// File: rtl/two_port_req_mux_pkg.sv
// Shared types for the two-port request mux: FSM states, owner index, held request entry.
package two_port_req_mux_pkg;

  // Entries are sized for the widest supported configuration; unused upper bits stay zero.
  localparam int unsigned MaxAddrW = 64;
  localparam int unsigned MaxDataW = 128;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitResp = 2'd2,
    StRelease  = 2'd3
  } state_e;

  typedef logic owner_t;

  typedef struct packed {
    logic                we;
    logic [MaxAddrW-1:0] addr;
    logic [MaxDataW-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/two_port_req_mux_if.sv
// Requester-side bus of the two-port mux: per-port request handshake plus shared response.
interface two_port_req_mux_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) ();
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             resp_valid;
  logic [1:0]             resp_err;
  logic [DATA_W-1:0]      resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/req_hold_slot.sv
// One-entry request holding register with valid/ready capture and an external clear.
module req_hold_slot
  import two_port_req_mux_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  input  req_entry_t entry_i,
  input  logic       clear_i,
  output logic       ready_o,
  output logic       full_o,
  output req_entry_t entry_o
);
  logic       live_q;
  logic       full_q, full_d;
  logic       capture;
  req_entry_t entry_q, entry_d;

  // live_q keeps ready low while in reset; it rises on the first clock afterwards.
  assign ready_o = live_q & ~full_q;
  assign capture = valid_i & ready_o;
  assign full_o  = full_q;
  assign entry_o = entry_q;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (capture) begin
      full_d  = 1'b1;
      entry_d = entry_i;
    end else if (clear_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q  <= 1'b0;
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      live_q  <= 1'b1;
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/two_port_req_mux.sv
// Two-requester front end onto one downstream memory channel, arbitrated externally.
// Optional response watchdog: define TWO_PORT_REQ_MUX_TIMEOUT_EN.
module two_port_req_mux
  import two_port_req_mux_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  two_port_req_mux_if.slave req_bus_io,
  output logic [1:0]        arb_req_o,
  input  logic [1:0]        arb_grant_i,
  output logic              arb_ack_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_rdata_i
);
  state_e     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [1:0] full, ready, clear, hit, owner_oh;
  logic       in_wait, data_fire, timeout_hit, resp_fire;
  req_entry_t slot_entry [2];

  for (genvar i = 0; i < 2; i++) begin : g_slot
    req_entry_t slot_in;
    always_comb begin
      slot_in                   = '0;
      slot_in.we                = req_bus_io.req_we[i];
      slot_in.addr[ADDR_W-1:0]  = req_bus_io.req_addr[i];
      slot_in.wdata[DATA_W-1:0] = req_bus_io.req_wdata[i];
    end

    req_hold_slot u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (req_bus_io.req_valid[i]),
      .entry_i (slot_in),
      .clear_i (clear[i]),
      .ready_o (ready[i]),
      .full_o  (full[i]),
      .entry_o (slot_entry[i])
    );
  end

  // Grants to an empty slot are ignored; port 0 wins if both bits ever appear.
  assign hit      = arb_grant_i & full;
  assign owner_oh = owner_q ? 2'b10 : 2'b01;
  assign in_wait  = (state_q == StWaitResp);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      StIdle: begin
        if (hit != 2'b00) begin
          owner_d = ~hit[0];
          state_d = StIssue;
        end
      end
      StIssue:    if (mem_req_ready_i) state_d = StWaitResp;
      StWaitResp: if (resp_fire) state_d = StRelease;
      StRelease:  state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign arb_req_o       = full;
  assign arb_ack_o       = (state_q == StRelease);
  assign clear           = arb_ack_o ? owner_oh : 2'b00;
  assign mem_req_valid_o = (state_q == StIssue);
  assign mem_req_we_o    = slot_entry[owner_q].we;
  assign mem_req_addr_o  = slot_entry[owner_q].addr[ADDR_W-1:0];
  assign mem_req_wdata_o = slot_entry[owner_q].wdata[DATA_W-1:0];

  assign data_fire             = in_wait & mem_resp_valid_i;
  assign resp_fire             = in_wait & (mem_resp_valid_i | timeout_hit);
  assign req_bus_io.req_ready  = ready;
  assign req_bus_io.resp_valid = resp_fire ? owner_oh : 2'b00;
  assign req_bus_io.resp_rdata = data_fire ? mem_resp_rdata_i : '0;

  logic unused_entry_hi;
  assign unused_entry_hi = ^{slot_entry[0], slot_entry[1]};

`ifdef TWO_PORT_REQ_MUX_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts WAIT_RESP cycles; restarts from zero on every entry into the state.
  assign cnt_d       = in_wait ? cnt_q + 1'b1 : '0;
  assign timeout_hit = in_wait && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign req_bus_io.resp_err = (resp_fire && !mem_resp_valid_i) ? owner_oh : 2'b00;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit         = 1'b0;
  assign req_bus_io.resp_err = 2'b00;
`endif

endmodule

// File: tb/tb_two_port_req_mux.sv
// Directed bench for two_port_req_mux with a registered round-robin arbiter model.
module tb_two_port_req_mux;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  two_port_req_mux_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [1:0]    arb_req, arb_grant;
  logic          arb_ack, last_q;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_rdata;
  int            checks = 0;
  int            errors = 0;
  int            ack_total = 0;
  int            ack_base;

  two_port_req_mux #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_bus_io       (bus),
    .arb_req_o        (arb_req),
    .arb_grant_i      (arb_grant),
    .arb_ack_o        (arb_ack),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_we_o     (mem_req_we),
    .mem_req_addr_o   (mem_req_addr),
    .mem_req_wdata_o  (mem_req_wdata),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_rdata_i (mem_resp_rdata)
  );

  // Round-robin arbiter: registered grant, held until ack, port 0 preferred after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_grant <= 2'b00;
      last_q    <= 1'b1;
    end else if (arb_ack) begin
      arb_grant <= 2'b00;
    end else if (arb_grant == 2'b00) begin
      if (arb_req[0] && (!arb_req[1] || last_q)) begin
        arb_grant <= 2'b01;
        last_q    <= 1'b0;
      end else if (arb_req[1]) begin
        arb_grant <= 2'b10;
        last_q    <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (arb_ack === 1'b1) ack_total <= ack_total + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic we, input logic [31:0] addr,
                      input logic [63:0] wdata);
    chk($sformatf("push%0d_ready", port), {63'd0, bus.req_ready[port]}, 64'd1);
    bus.req_valid[port] = 1'b1;
    bus.req_we[port]    = we;
    bus.req_addr[port]  = addr;
    bus.req_wdata[port] = wdata;
    tick();
    bus.req_valid[port] = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_issue"}, {63'd0, mem_req_valid}, 64'd1);
  endtask

  task automatic serve(input string tag, input int port, input logic [31:0] addr,
                       input logic [63:0] rdata);
    logic [1:0] exp_v;
    exp_v = (port == 0) ? 2'b01 : 2'b10;
    mem_req_ready = 1'b1;
    wait_issue(tag);
    chk({tag, "_addr"}, {32'd0, mem_req_addr}, {32'd0, addr});
    tick();
    chk({tag, "_single_issue"}, {63'd0, mem_req_valid}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    settle();
    chk({tag, "_resp_valid"}, {62'd0, bus.resp_valid}, {62'd0, exp_v});
    chk({tag, "_rdata"}, bus.resp_rdata, rdata);
    chk({tag, "_no_ack_with_resp"}, {63'd0, arb_ack}, 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    settle();
    chk({tag, "_resp_pulse_end"}, {62'd0, bus.resp_valid}, 64'd0);
    chk({tag, "_ack"}, {63'd0, arb_ack}, 64'd1);
    tick();
    chk({tag, "_ack_one_cycle"}, {63'd0, arb_ack}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, bus.req_ready[port]}, 64'd1);
  endtask

  task automatic reset_dut();
    bus.req_valid  = 2'b00;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    rst_n = 1'b0;
    settle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("rst_arb_req", {62'd0, arb_req}, 64'd0);
    chk("rst_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_ack", {63'd0, arb_ack}, 64'd0);
    chk("rst_resp_valid", {62'd0, bus.resp_valid}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_req_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {62'd0, bus.req_ready}, 64'd3);

    // Single read on port 0, response arrives on the second WAIT_RESP cycle
    mem_req_ready = 1'b1;
    push(0, 1'b0, 32'h100, 64'h0);
    settle();
    chk("t1_arb_req", {62'd0, arb_req}, 64'd1);
    chk("t1_ready_held", {62'd0, bus.req_ready}, 64'd2);
    chk("t1_c1_no_issue", {63'd0, mem_req_valid}, 64'd0);
    tick();
    chk("t1_c2_no_issue", {63'd0, mem_req_valid}, 64'd0);
    tick();
    chk("t1_c3_issue", {63'd0, mem_req_valid}, 64'd1);
    chk("t1_addr", {32'd0, mem_req_addr}, 64'h100);
    chk("t1_we", {63'd0, mem_req_we}, 64'd0);
    tick();
    chk("t1_c4_single_issue", {63'd0, mem_req_valid}, 64'd0);
    chk("t1_c4_no_resp", {62'd0, bus.resp_valid}, 64'd0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD;
    settle();
    chk("t1_resp_valid", {62'd0, bus.resp_valid}, 64'd1);
    chk("t1_rdata", bus.resp_rdata, 64'hDEAD);
    chk("t1_no_ack_yet", {63'd0, arb_ack}, 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("t1_ack", {63'd0, arb_ack}, 64'd1);
    chk("t1_resp_done", {62'd0, bus.resp_valid}, 64'd0);
    chk("t1_arb_req_until_ack", {62'd0, arb_req}, 64'd1);
    chk("t1_ready_low_in_release", {62'd0, bus.req_ready}, 64'd2);
    tick();
    chk("t1_ack_done", {63'd0, arb_ack}, 64'd0);
    chk("t1_ready_back", {62'd0, bus.req_ready}, 64'd3);
    chk("t1_arb_req_clear", {62'd0, arb_req}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBAD;
    settle();
    chk("t1_stale_resp_ignored", {62'd0, bus.resp_valid}, 64'd0);
    chk("t1_stale_rdata_zero", bus.resp_rdata, 64'd0);
    mem_resp_valid = 1'b0;

    // Both ports request together after reset: port 0 first, then port 1
    reset_dut();
    ack_base = ack_total;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h300, 32'h200};
    tick();
    bus.req_valid = 2'b00;
    serve("t2_p0", 0, 32'h200, 64'h1111);
    serve("t2_p1", 1, 32'h300, 64'h2222);
    chk("t2_two_acks", 64'(ack_total - ack_base), 64'd2);
    chk("t2_none_pending", {62'd0, arb_req}, 64'd0);

    // Port 0 re-requests after each ack while port 1 stays pending
    bus.req_valid = 2'b11;
    bus.req_addr  = {32'h410, 32'h400};
    tick();
    bus.req_valid = 2'b00;
    serve("t3_a0", 0, 32'h400, 64'hA0);
    push(0, 1'b0, 32'h401, 64'h0);
    serve("t3_b1", 1, 32'h410, 64'hB1);
    push(1, 1'b0, 32'h411, 64'h0);
    serve("t3_c0", 0, 32'h401, 64'hC0);
    push(0, 1'b0, 32'h402, 64'h0);
    serve("t3_d1", 1, 32'h411, 64'hD1);
    serve("t3_e0", 0, 32'h402, 64'hE0);

    // Downstream stall: payload must hold for 5 cycles with a single issue
    mem_req_ready = 1'b0;
    push(1, 1'b1, 32'h555, 64'h1234_5678_9ABC_DEF0);
    wait_issue("t4");
    for (int k = 0; k < 5; k++) begin
      chk("t4_valid_held", {63'd0, mem_req_valid}, 64'd1);
      chk("t4_addr_stable", {32'd0, mem_req_addr}, 64'h555);
      chk("t4_wdata_stable", mem_req_wdata, 64'h1234_5678_9ABC_DEF0);
      chk("t4_we_stable", {63'd0, mem_req_we}, 64'd1);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    chk("t4_single_issue", {63'd0, mem_req_valid}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h77;
    settle();
    chk("t4_resp_valid", {62'd0, bus.resp_valid}, 64'd2);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("t4_ack", {63'd0, arb_ack}, 64'd1);
    tick();

    // No downstream response
    push(0, 1'b0, 32'h600, 64'h0);
    wait_issue("t5");
    tick();
`ifdef TWO_PORT_REQ_MUX_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      chk("t5_no_early_timeout", {62'd0, bus.resp_valid}, 64'd0);
      tick();
    end
    chk("t5_timeout_valid", {62'd0, bus.resp_valid}, 64'd1);
    chk("t5_timeout_err", {62'd0, bus.resp_err}, 64'd1);
    chk("t5_timeout_rdata", bus.resp_rdata, 64'd0);
    chk("t5_no_ack_with_resp", {63'd0, arb_ack}, 64'd0);
    tick();
    chk("t5_ack", {63'd0, arb_ack}, 64'd1);
    chk("t5_err_cleared", {62'd0, bus.resp_err}, 64'd0);
    tick();
`else
    for (int k = 0; k < 20; k++) begin
      chk("t5_still_waiting", {62'd0, bus.resp_valid}, 64'd0);
      chk("t5_no_ack", {63'd0, arb_ack}, 64'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBEEF;
    settle();
    chk("t5_late_resp", {62'd0, bus.resp_valid}, 64'd1);
    chk("t5_no_err", {62'd0, bus.resp_err}, 64'd0);
    tick();
    mem_resp_valid = 1'b0;
    settle();
    chk("t5_ack", {63'd0, arb_ack}, 64'd1);
    tick();
`endif

    // Reset during WAIT_RESP abandons the transaction
    push(1, 1'b0, 32'h700, 64'h0);
    wait_issue("t6");
    tick();
    ack_base = ack_total;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ready", {62'd0, bus.req_ready}, 64'd0);
    chk("t6_async_arb_req", {62'd0, arb_req}, 64'd0);
    chk("t6_async_mem_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("t6_async_ack", {63'd0, arb_ack}, 64'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'h5555;
    settle();
    chk("t6_resp_in_reset", {62'd0, bus.resp_valid}, 64'd0);
    chk("t6_rdata_in_reset", bus.resp_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_stale_resp_1", {62'd0, bus.resp_valid}, 64'd0);
    chk("t6_ready_first_clk", {62'd0, bus.req_ready}, 64'd3);
    tick();
    chk("t6_stale_resp_2", {62'd0, bus.resp_valid}, 64'd0);
    chk("t6_no_ack", 64'(ack_total - ack_base), 64'd0);
    mem_resp_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
